// File: rtl/ov7670_frame_sequencer.sv
// OV7670 capture front end: synchronises the camera pins, pairs bytes into RGB565
// pixels, tracks frame position and hands pixels to the display side through a small FIFO.
module ov7670_frame_sequencer #(
    parameter int H_PIXELS   = 320,
    parameter int V_LINES    = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           vsync,
    input  logic                           href,
    input  logic                           pclk,
    input  logic [7:0]                     camData,
    output logic                           frameStart,
    output logic                           pixelValid,
    input  logic                           pixelReady,
    output logic [15:0]                    pixelData,
    output logic                           frameBusy,
    output logic [$clog2(V_LINES+1)-1:0]   rowCount,
    input  logic                           errClear,
    output logic                           lineErr,
    output logic                           frameErr,
    output logic                           ovfErr
);

    localparam int CW = $clog2(H_PIXELS + 1);
    localparam int RW = $clog2(V_LINES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] H_VAL   = CW'(H_PIXELS);
    localparam logic [CW-1:0] COL_MAX = '1;
    localparam logic [RW-1:0] V_VAL   = RW'(V_LINES);
    localparam logic [NW-1:0] FULL_VAL = NW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE, DONE} state_t;

    logic       vsyncS1_q, vsyncS2_q, vsyncS3_q;
    logic       hrefS1_q, hrefS2_q, hrefS3_q;
    logic       pclkS1_q, pclkS2_q, pclkS3_q;
    logic [7:0] camS1_q, camS2_q;

    state_t          state_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic            phase_q;
    logic [7:0]      hiByte_q;
    logic            frameStart_q;
    logic            frameBusy_q;

    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr_q, rdPtr_q;
    logic [NW-1:0]   count_q, count_d;

    logic lineErr_q, frameErr_q, ovfErr_q;

    logic pclkRise, vsyncRise, vsyncFall, hrefFall;
    logic isActive, byteStrobe, startFrame, flush;
    logic pushReq, pop, full, doPush, dropped;
    logic lineEvt, frameEvt;
    logic [RW-1:0] rowInc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vsyncS1_q <= 1'b0; vsyncS2_q <= 1'b0; vsyncS3_q <= 1'b0;
            hrefS1_q  <= 1'b0; hrefS2_q  <= 1'b0; hrefS3_q  <= 1'b0;
            pclkS1_q  <= 1'b0; pclkS2_q  <= 1'b0; pclkS3_q  <= 1'b0;
            camS1_q   <= '0;   camS2_q   <= '0;
        end else begin
            vsyncS1_q <= vsync;     vsyncS2_q <= vsyncS1_q; vsyncS3_q <= vsyncS2_q;
            hrefS1_q  <= href;      hrefS2_q  <= hrefS1_q;  hrefS3_q  <= hrefS2_q;
            pclkS1_q  <= pclk;      pclkS2_q  <= pclkS1_q;  pclkS3_q  <= pclkS2_q;
            camS1_q   <= camData;   camS2_q   <= camS1_q;
        end
    end

    assign pclkRise  = pclkS2_q & ~pclkS3_q;
    assign vsyncRise = vsyncS2_q & ~vsyncS3_q;
    assign vsyncFall = ~vsyncS2_q & vsyncS3_q;
    assign hrefFall  = ~hrefS2_q & hrefS3_q;

    assign isActive   = enable & (state_q == ACTIVE);
    assign byteStrobe = pclkRise & hrefS2_q;
    assign startFrame = enable & (state_q == VBLANK) & vsyncFall;
    assign flush      = ~enable | startFrame;
    assign rowInc     = row_q + RW'(1);

    // A vsync rise ends the active region, so nothing else in that cycle counts toward the frame.
    assign pushReq  = isActive & ~vsyncRise & byteStrobe & phase_q & (col_q < H_VAL) & ~flush;
    assign lineEvt  = isActive & ~vsyncRise & hrefFall & ((col_q != H_VAL) | phase_q);
    assign frameEvt = isActive & vsyncRise & (row_q < V_VAL);

    assign pixelValid = (count_q != '0);
    assign full       = (count_q == FULL_VAL);
    assign pop        = pixelValid & pixelReady;
    assign doPush     = pushReq & (~full | pop);
    assign dropped    = pushReq & full & ~pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            row_q        <= '0;
            col_q        <= '0;
            phase_q      <= 1'b0;
            hiByte_q     <= '0;
            frameStart_q <= 1'b0;
            frameBusy_q  <= 1'b0;
        end else begin
            frameStart_q <= 1'b0;
            if (!enable) begin
                state_q     <= IDLE;
                row_q       <= '0;
                col_q       <= '0;
                phase_q     <= 1'b0;
                frameBusy_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (vsyncRise) state_q <= VBLANK;
                    end
                    VBLANK: begin
                        if (vsyncFall) begin
                            state_q      <= ACTIVE;
                            frameStart_q <= 1'b1;
                            frameBusy_q  <= 1'b1;
                            row_q        <= '0;
                            col_q        <= '0;
                            phase_q      <= 1'b0;
                        end
                    end
                    ACTIVE: begin
                        if (vsyncRise) begin
                            state_q     <= VBLANK;
                            frameBusy_q <= 1'b0;
                        end else if (hrefFall) begin
                            row_q   <= rowInc;
                            col_q   <= '0;
                            phase_q <= 1'b0;
                            if (rowInc == V_VAL) begin
                                state_q     <= DONE;
                                frameBusy_q <= 1'b0;
                            end
                        end else if (byteStrobe) begin
                            phase_q <= ~phase_q;
                            if (!phase_q) hiByte_q <= camS2_q;
                            else if (col_q != COL_MAX) col_q <= col_q + CW'(1);
                        end
                    end
                    DONE: begin
                        if (vsyncRise) state_q <= VBLANK;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (doPush && !pop)      count_d = count_q + NW'(1);
        else if (!doPush && pop) count_d = count_q - NW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
            if (pop)    rdPtr_q <= rdPtr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: pixelData is gated to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q] <= {hiByte_q, camS2_q};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lineErr_q  <= 1'b0;
            frameErr_q <= 1'b0;
            ovfErr_q   <= 1'b0;
        end else begin
            lineErr_q  <= lineEvt  | (lineErr_q  & ~errClear);
            frameErr_q <= frameEvt | (frameErr_q & ~errClear);
            ovfErr_q   <= dropped  | (ovfErr_q   & ~errClear);
        end
    end

    assign pixelData  = pixelValid ? mem_q[rdPtr_q] : 16'h0000;
    assign frameStart = frameStart_q;
    assign frameBusy  = frameBusy_q;
    assign rowCount   = row_q;
    assign lineErr    = lineErr_q;
    assign frameErr   = frameErr_q;
    assign ovfErr     = ovfErr_q;

endmodule

// File: tb/tb_ov7670_frame_sequencer.sv
// Scoreboard bench for ov7670_frame_sequencer: drives camera pins, predicts forwarded
// pixels and sticky flags from the line/frame rules, and checks them as the DUT emits.
module tb_ov7670_frame_sequencer;

    localparam int H = 4;
    localparam int V = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        vsync = 1'b0;
    logic        href = 1'b0;
    logic        pclk = 1'b0;
    logic [7:0]  camData = 8'h00;
    logic        pixelReady = 1'b1;
    logic        errClear = 1'b0;
    logic        frameStart, pixelValid, frameBusy, lineErr, frameErr, ovfErr;
    logic [15:0] pixelData;
    logic [1:0]  rowCount;

    ov7670_frame_sequencer #(.H_PIXELS(H), .V_LINES(V), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset(reset), .enable(enable), .vsync(vsync), .href(href),
        .pclk(pclk), .camData(camData), .frameStart(frameStart),
        .pixelValid(pixelValid), .pixelReady(pixelReady), .pixelData(pixelData),
        .frameBusy(frameBusy), .rowCount(rowCount), .errClear(errClear),
        .lineErr(lineErr), .frameErr(frameErr), .ovfErr(ovfErr)
    );

    always #5 clk = ~clk;

    int          nVec = 0;
    int          nErr = 0;
    logic [15:0] expQ[$];
    logic [7:0]  lineBytes[16];
    int          rows = 0;
    bit          modelActive = 0;
    bit          expLineErr = 0, expFrameErr = 0, expOvf = 0;
    int          fsSeen = 0, fsExp = 0;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
        nVec++;
        if (act !== expv) begin
            nErr++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Monitor: every accepted pixel must be the oldest one the model predicted.
    always @(negedge clk) begin
        if (frameStart === 1'b1) fsSeen++;
        if (reset && pixelValid === 1'b1 && pixelReady) begin
            if (expQ.size() == 0) begin
                nVec++;
                nErr++;
                $display("[TB] FAIL unexpectedPixel: got %h, expected no pixel", pixelData);
            end else begin
                checkOutput("pixel", pixelData, expQ.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b, input int stretch);
        camData = b;
        pclk = 1'b0;
        tick(2 + stretch);
        pclk = 1'b1;
        tick(2);
    endtask

    task automatic checkErrors(input string tag);
        checkOutput({tag, ".lineErr"},  lineErr,  expLineErr);
        checkOutput({tag, ".frameErr"}, frameErr, expFrameErr);
        checkOutput({tag, ".ovfErr"},   ovfErr,   expOvf);
    endtask

    // One camera line of n bytes from lineBytes; the model decides which pixels get forwarded.
    task automatic applyStimulus(input int n, input bit clrAtFall, input int maxStretch, input bit endLine);
        bit evt;
        href = 1'b1;
        tick(2);
        for (int i = 0; i < n; i++) begin
            if ((i % 2) == 1 && modelActive && (i / 2) < H) begin
                if (expQ.size() < D) expQ.push_back({lineBytes[i-1], lineBytes[i]});
                else expOvf = 1;
            end
            sendByte(lineBytes[i], int'($urandom_range(maxStretch, 0)));
        end
        if (!endLine) return;
        pclk = 1'b0;
        tick(2);
        href = 1'b0;
        evt = modelActive && (((n / 2) != H) || ((n % 2) == 1));
        if (modelActive) begin
            rows++;
            if (rows == V) modelActive = 0;
        end
        if (evt) expLineErr = 1;
        if (clrAtFall) begin
            tick(2);
            errClear = 1'b1;
            tick(1);
            errClear = 1'b0;
            expOvf = 0;
            expFrameErr = 0;
            expLineErr = evt;
            tick(3);
        end else begin
            tick(6);
        end
    endtask

    task automatic vsyncPulse();
        if (modelActive && rows < V) expFrameErr = 1;
        vsync = 1'b1;
        tick(8);
        checkOutput("frameErrAtVsync", frameErr, expFrameErr);
        checkOutput("busyInVblank", frameBusy, 0);
        vsync = 1'b0;
        tick(2);
        checkOutput("frameStartEarly", frameStart, 0);
        tick(1);
        checkOutput("frameStart", frameStart, 1);
        fsExp++;
        expQ.delete();
        rows = 0;
        modelActive = 1;
        tick(1);
        checkOutput("frameStartWidth", frameStart, 0);
        checkOutput("busyActive", frameBusy, 1);
        tick(4);
    endtask

    task automatic errClearPulse();
        errClear = 1'b1;
        tick(1);
        errClear = 1'b0;
        expLineErr = 0;
        expFrameErr = 0;
        expOvf = 0;
        tick(1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && expQ.size() > 0; i++) tick(1);
        checkOutput({tag, ".pendingPixels"}, 16'(expQ.size()), 0);
    endtask

    task automatic fillSeq(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) lineBytes[i] = base + 8'(i);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick(5);
        checkOutput("rstHold.valid", pixelValid, 0);
        checkOutput("rstHold.busy", frameBusy, 0);
        reset = 1'b1;
        tick(1);
        checkOutput("rst.valid", pixelValid, 0);
        checkOutput("rst.data", pixelData, 0);
        checkOutput("rst.frameStart", frameStart, 0);
        checkOutput("rst.busy", frameBusy, 0);
        checkOutput("rst.rowCount", rowCount, 0);
        checkErrors("rst");

        // Full frame with a free-running consumer.
        pixelReady = 1'b1;
        vsyncPulse();
        fillSeq(8, 8'h01);
        applyStimulus(8, 0, 0, 1);
        checkOutput("full.rowCount1", rowCount, 1);
        checkOutput("full.busyMid", frameBusy, 1);
        fillSeq(8, 8'h11);
        applyStimulus(8, 0, 0, 1);
        drain("full");
        checkOutput("full.rowCount2", rowCount, 2);
        checkOutput("full.busyDone", frameBusy, 0);
        checkErrors("full");

        // Backpressure: first line fills the FIFO, second line overflows it.
        pixelReady = 1'b0;
        vsyncPulse();
        fillSeq(12, 8'h01);
        applyStimulus(12, 0, 0, 1);
        checkOutput("bp.valid", pixelValid, 1);
        checkOutput("bp.head", pixelData, 16'h0102);
        checkErrors("bp.line1");
        fillSeq(4, 8'h21);
        applyStimulus(4, 0, 0, 1);
        checkErrors("bp.line2");
        errClearPulse();
        checkErrors("bp.cleared");
        pixelReady = 1'b1;
        drain("bp");

        // Short lines, second one with errClear landing on the line-end event.
        vsyncPulse();
        fillSeq(3, 8'h31);
        applyStimulus(3, 0, 0, 1);
        checkErrors("short1");
        fillSeq(3, 8'h41);
        applyStimulus(3, 1, 0, 1);
        checkErrors("short2.clrCollide");
        errClearPulse();
        checkErrors("short.cleared");
        drain("short");

        // Early vsync: frameErr, then the new frame flushes stale pixels.
        pixelReady = 1'b0;
        vsyncPulse();
        fillSeq(4, 8'h51);
        applyStimulus(4, 0, 0, 1);
        checkOutput("early.valid", pixelValid, 1);
        checkOutput("early.head", pixelData, 16'h5152);
        vsyncPulse();
        checkOutput("early.flushed", pixelValid, 0);
        checkErrors("early");
        errClearPulse();
        checkErrors("early.cleared");

        // Disable mid-line, then re-enable without vsync.
        fillSeq(4, 8'h61);
        applyStimulus(4, 0, 0, 0);
        tick(6);
        checkOutput("dis.validBefore", pixelValid, 1);
        enable = 1'b0;
        tick(1);
        checkOutput("dis.busy", frameBusy, 0);
        checkOutput("dis.valid", pixelValid, 0);
        checkOutput("dis.rowCount", rowCount, 0);
        expQ.delete();
        modelActive = 0;
        pclk = 1'b0;
        href = 1'b0;
        tick(4);
        enable = 1'b1;
        pixelReady = 1'b1;
        fillSeq(8, 8'h65);
        applyStimulus(8, 0, 0, 1);
        checkOutput("reen.valid", pixelValid, 0);
        checkErrors("reen");

        // Random frames with random data, line lengths and pclk stretching.
        for (int f = 0; f < 3; f++) begin
            vsyncPulse();
            for (int l = 0; l < V; l++) begin
                int n;
                n = int'($urandom_range(10, 7));
                for (int i = 0; i < n; i++) lineBytes[i] = 8'($urandom);
                applyStimulus(n, 0, 3, 1);
            end
            drain("rand");
            checkOutput("rand.rowCount", rowCount, 2);
            checkOutput("rand.busy", frameBusy, 0);
            checkErrors("rand");
            errClearPulse();
        end

        // Reset mid-ACTIVE with three pixels buffered.
        pixelReady = 1'b0;
        vsyncPulse();
        fillSeq(6, 8'h81);
        applyStimulus(6, 0, 0, 1);
        checkOutput("midRst.validBefore", pixelValid, 1);
        checkOutput("midRst.lineErrBefore", lineErr, 1);
        reset = 1'b0;
        tick(5);
        expQ.delete();
        modelActive = 0;
        expLineErr = 0;
        expFrameErr = 0;
        expOvf = 0;
        reset = 1'b1;
        tick(1);
        checkOutput("midRst.valid", pixelValid, 0);
        checkOutput("midRst.data", pixelData, 0);
        checkOutput("midRst.busy", frameBusy, 0);
        checkOutput("midRst.rowCount", rowCount, 0);
        checkOutput("midRst.frameStart", frameStart, 0);
        checkErrors("midRst");
        pixelReady = 1'b1;
        tick(10);
        checkOutput("frameStartCount", 16'(fsSeen), 16'(fsExp));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
